// File: rtl/vadd_pkg.sv
// Shared constants for the vector-add loader and kernel: word width,
// default vector length and the loader FSM state encodings.
package vadd_pkg;

  localparam int WORD_W        = 32;
  localparam int DATA_SIZE_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

endpackage

// File: rtl/vadd_loader_credit_ctr.sv
// Outstanding-read counter. has_credit reflects the count after this cycle's
// request/response events, so the issuer can decide next cycle's request now.
module credit_ctr #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic has_credit
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // Next count: a simultaneous request and response cancel out
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (inc && !dec) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (dec && !inc && (count_r != {CNT_W{1'b0}})) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  assign has_credit = (count_nxt_s < CNT_W'(MAX_OUT));

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/vadd_loader.sv
// Fetches vector A then vector B through an in-order pipelined read port into
// flat buffers and holds them for the kernel until it acknowledges completion.
module vadd_loader
  import vadd_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUT   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_a,
  input  logic [ADDR_W-1:0]           base_b,
  output logic                        busy,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [ADDR_W-1:0]           mem_req_addr,
  input  logic                        mem_rsp_valid,
  input  logic [WORD_W-1:0]           mem_rsp_data,
  output logic [DATA_SIZE*WORD_W-1:0] a_out,
  output logic [DATA_SIZE*WORD_W-1:0] b_out,
  output logic                        in_ready,
  input  logic                        done_ack
);

  localparam int TOTAL = 2 * DATA_SIZE;
  localparam int IDX_W = $clog2(TOTAL + 1);

  logic [1:0]                  state_r;
  logic [ADDR_W-1:0]           base_a_r;
  logic [ADDR_W-1:0]           base_b_r;
  logic [IDX_W-1:0]            req_idx_r;
  logic [IDX_W-1:0]            rsp_idx_r;
  logic                        req_valid_r;
  logic [ADDR_W-1:0]           req_addr_r;
  logic                        busy_r;
  logic                        in_ready_r;
  logic [DATA_SIZE*WORD_W-1:0] a_buf_r;
  logic [DATA_SIZE*WORD_W-1:0] b_buf_r;

  logic             start_acc_s;
  logic             req_hs_s;
  logic             rsp_acc_s;
  logic             last_req_s;
  logic             last_rsp_s;
  logic             has_credit_s;
  logic [IDX_W-1:0] req_idx_nxt_s;

  // Request k maps to A for the first DATA_SIZE requests, then to B; wraps mod 2^ADDR_W
  function automatic logic [ADDR_W-1:0] req_addr_f(
    input logic [IDX_W-1:0]  k,
    input logic [ADDR_W-1:0] ba,
    input logic [ADDR_W-1:0] bb
  );
    logic [ADDR_W-1:0] addr;
    if (k < IDX_W'(DATA_SIZE)) begin
      addr = ba + ADDR_W'(k);
    end else begin
      addr = bb + ADDR_W'(k - IDX_W'(DATA_SIZE));
    end
    return addr;
  endfunction

  assign start_acc_s   = (state_r == ST_IDLE) && start;
  assign req_hs_s      = req_valid_r && mem_req_ready;
  assign rsp_acc_s     = mem_rsp_valid && ((state_r == ST_FETCH) || (state_r == ST_DRAIN));
  assign last_req_s    = req_hs_s && (req_idx_r == IDX_W'(TOTAL - 1));
  assign last_rsp_s    = rsp_acc_s && (rsp_idx_r == IDX_W'(TOTAL - 1));
  assign req_idx_nxt_s = req_hs_s ? (req_idx_r + IDX_W'(1)) : req_idx_r;

  credit_ctr #(
    .MAX_OUT (MAX_OUT)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_acc_s),
    .inc        (req_hs_s),
    .dec        (rsp_acc_s),
    .has_credit (has_credit_s)
  );

  // Control FSM and request issue; a pending request is held until handshaken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      base_a_r    <= {ADDR_W{1'b0}};
      base_b_r    <= {ADDR_W{1'b0}};
      req_idx_r   <= {IDX_W{1'b0}};
      req_valid_r <= 1'b0;
      req_addr_r  <= {ADDR_W{1'b0}};
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_FETCH;
            base_a_r    <= base_a;
            base_b_r    <= base_b;
            req_idx_r   <= {IDX_W{1'b0}};
            req_valid_r <= 1'b1;
            req_addr_r  <= base_a;
            busy_r      <= 1'b1;
          end
        end
        ST_FETCH: begin
          req_idx_r <= req_idx_nxt_s;
          if (last_req_s) begin
            state_r     <= ST_DRAIN;
            req_valid_r <= 1'b0;
          end else begin
            req_valid_r <= (req_valid_r && !mem_req_ready) || has_credit_s;
            req_addr_r  <= req_addr_f(req_idx_nxt_s, base_a_r, base_b_r);
          end
        end
        ST_DRAIN: begin
          if (last_rsp_s) begin
            state_r    <= ST_FULL;
            in_ready_r <= 1'b1;
          end
        end
        ST_FULL: begin
          if (done_ack) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  // Response capture; buffers persist across loads and are only cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_idx_r <= {IDX_W{1'b0}};
      a_buf_r   <= {(DATA_SIZE*WORD_W){1'b0}};
      b_buf_r   <= {(DATA_SIZE*WORD_W){1'b0}};
    end else if (start_acc_s) begin
      rsp_idx_r <= {IDX_W{1'b0}};
    end else if (rsp_acc_s) begin
      rsp_idx_r <= rsp_idx_r + IDX_W'(1);
      for (int i = 0; i < DATA_SIZE; i++) begin
        if (rsp_idx_r == IDX_W'(i)) begin
          a_buf_r[i*WORD_W +: WORD_W] <= mem_rsp_data;
        end
        if (rsp_idx_r == IDX_W'(i + DATA_SIZE)) begin
          b_buf_r[i*WORD_W +: WORD_W] <= mem_rsp_data;
        end
      end
    end
  end

  assign busy          = busy_r;
  assign in_ready      = in_ready_r;
  assign mem_req_valid = req_valid_r;
  assign mem_req_addr  = req_addr_r;
  assign a_out         = a_buf_r;
  assign b_out         = b_buf_r;

endmodule

// File: tb/tb_vadd_loader.sv
// Directed bench for vadd_loader (N=4, MAX_OUT=4) with an in-order memory
// model of latency 2 whose responses can be throttled by a response budget.
module tb_vadd_loader;
  import vadd_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int MO = 4;
  localparam int L  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     base_a;
  logic [AW-1:0]     base_b;
  logic              busy;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic [N*32-1:0]   a_out;
  logic [N*32-1:0]   b_out;
  logic              in_ready;
  logic              done_ack;

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  int          hs_total = 0;
  int          rsp_total = 0;
  int          last_rsp_cyc = 0;
  int          rsp_budget = 0;
  int          rdy_cyc = 0;
  logic [31:0] hs_log [0:255];
  logic [31:0] q_addr [$];
  int          q_t [$];

  vadd_loader #(
    .DATA_SIZE (N),
    .ADDR_W    (AW),
    .MAX_OUT   (MO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_a        (base_a),
    .base_b        (base_b),
    .busy          (busy),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .a_out         (a_out),
    .b_out         (b_out),
    .in_ready      (in_ready),
    .done_ack      (done_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] base);
    logic [31:0] b0, b1, b2, b3;
    b0 = base;
    b1 = base + 32'd1;
    b2 = base + 32'd2;
    b3 = base + 32'd3;
    return {b3, b2, b1, b0};
  endfunction

  // Memory model, edge side: consume delivered responses, log request handshakes
  initial begin
    logic [31:0] dummy_a;
    int          dummy_t;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        q_addr.delete();
        q_t.delete();
      end else begin
        if (mem_rsp_valid) begin
          dummy_a = q_addr.pop_front();
          dummy_t = q_t.pop_front();
          rsp_total++;
          rsp_budget--;
          last_rsp_cyc = cyc;
        end
        if (mem_req_valid && mem_req_ready) begin
          hs_log[hs_total % 256] = mem_req_addr;
          hs_total++;
          q_addr.push_back(mem_req_addr);
          q_t.push_back(cyc);
        end
      end
    end
  end

  // Memory model, drive side: data equals the requested address, L cycles later
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && (q_addr.size() > 0) && (rsp_budget > 0) && (cyc >= q_t[0] + L - 1)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = q_addr[0];
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_load(input logic [31:0] ba, input logic [31:0] bb);
    @(negedge clk);
    start  = 1'b1;
    base_a = ba;
    base_b = bb;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    rdy_cyc = cyc;
    check(tag, in_ready, 1'b1);
  endtask

  task automatic ack(input string tag, input logic [127:0] exp_a);
    done_ack = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_a_kept"}, a_out, exp_a);
  endtask

  task automatic check_log(input string tag, input int h0, input logic [31:0] ba, input logic [31:0] bb);
    logic [31:0] exp;
    check({tag, "_hs_count"}, 128'(hs_total - h0), 128'(2 * N));
    for (int k = 0; k < 2 * N; k++) begin
      exp = (k < N) ? (ba + 32'(k)) : (bb + 32'(k - N));
      check($sformatf("%s_addr%0d", tag, k), hs_log[(h0 + k) % 256], exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int h0;
    int r0;
    int n;
    rst_n         = 1'b0;
    start         = 1'b0;
    base_a        = 32'd0;
    base_b        = 32'd0;
    mem_req_ready = 1'b1;
    done_ack      = 1'b0;
    rsp_budget    = 1000000;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_valid", mem_req_valid, 1'b0);
    check("rst_addr", mem_req_addr, 32'd0);
    check("rst_a_out", a_out, 128'd0);
    check("rst_b_out", b_out, 128'd0);
    rst_n = 1'b1;
    tick(1);

    // Nominal load
    h0 = hs_total;
    r0 = rsp_total;
    start_load(32'h100, 32'h200);
    check("nom_first_valid", mem_req_valid, 1'b1);
    check("nom_first_addr", mem_req_addr, 32'h100);
    check("nom_busy", busy, 1'b1);
    wait_ready("nom_in_ready");
    check("nom_rdy_latency", 128'(rdy_cyc), 128'(last_rsp_cyc));
    check("nom_rsp_count", 128'(rsp_total - r0), 128'(2 * N));
    check_log("nom", h0, 32'h100, 32'h200);
    check("nom_a_out", a_out, pack4(32'h100));
    check("nom_b_out", b_out, pack4(32'h200));
    ack("nom_ack", pack4(32'h100));

    // Backpressure at request 2
    h0 = hs_total;
    start_load(32'h100, 32'h200);
    n = 0;
    while (!(mem_req_valid && mem_req_addr == 32'h102) && n < 50) begin
      @(negedge clk);
      n++;
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_hold%0d", i), mem_req_valid, 1'b1);
      check($sformatf("bp_addr_hold%0d", i), mem_req_addr, 32'h102);
    end
    mem_req_ready = 1'b1;
    wait_ready("bp_in_ready");
    check_log("bp", h0, 32'h100, 32'h200);
    ack("bp_ack", pack4(32'h100));

    // Credit limit with withheld responses
    h0 = hs_total;
    r0 = rsp_total;
    rsp_budget = 0;
    start_load(32'h100, 32'h200);
    tick(10);
    check("cr_hs_at_limit", 128'(hs_total - h0), 128'(MO));
    check("cr_valid_low", mem_req_valid, 1'b0);
    rsp_budget = 1;
    tick(6);
    check("cr_hs_after_one", 128'(hs_total - h0), 128'(MO + 1));
    check("cr_valid_low2", mem_req_valid, 1'b0);
    rsp_budget = 2;
    tick(6);
    check("cr_hs_after_simul", 128'(hs_total - h0), 128'(MO + 3));
    check("cr_rsp_count", 128'(rsp_total - r0), 128'd3);
    check("cr_valid_low3", mem_req_valid, 1'b0);
    rsp_budget = 1000000;
    wait_ready("cr_in_ready");
    check_log("cr", h0, 32'h100, 32'h200);
    check("cr_b_out", b_out, pack4(32'h200));
    ack("cr_ack", pack4(32'h100));

    // Address wrap
    h0 = hs_total;
    start_load(32'hFFFF_FFFE, 32'h10);
    wait_ready("wrap_in_ready");
    check_log("wrap", h0, 32'hFFFF_FFFE, 32'h10);
    check("wrap_a_out", a_out, {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    ack("wrap_ack", {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});

    // Reset mid-FETCH after three responses
    r0 = rsp_total;
    rsp_budget = 3;
    start_load(32'h100, 32'h200);
    n = 0;
    while ((rsp_total - r0) < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tick(2);
    check("mr_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", mem_req_valid, 1'b0);
    check("mr_addr", mem_req_addr, 32'd0);
    check("mr_busy", busy, 1'b0);
    check("mr_in_ready", in_ready, 1'b0);
    check("mr_a_out", a_out, 128'd0);
    check("mr_b_out", b_out, 128'd0);
    tick(2);
    rst_n = 1'b1;
    rsp_budget = 1000000;
    tick(1);
    h0 = hs_total;
    start_load(32'h300, 32'h400);
    wait_ready("mr_reload_ready");
    check_log("mr", h0, 32'h300, 32'h400);
    check("mr_reload_a", a_out, pack4(32'h300));
    check("mr_reload_b", b_out, pack4(32'h400));
    ack("mr_ack", pack4(32'h300));

    // Protocol misuse: start in FETCH and done_ack in DRAIN are ignored
    h0 = hs_total;
    start_load(32'h100, 32'h200);
    start  = 1'b1;
    base_a = 32'h500;
    base_b = 32'h600;
    @(negedge clk);
    start  = 1'b0;
    n = 0;
    while ((hs_total - h0) < 2 * N && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mis_drain_busy", busy, 1'b1);
    check("mis_drain_not_ready", in_ready, 1'b0);
    done_ack = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
    check("mis_busy_after_ack", busy, 1'b1);
    wait_ready("mis_in_ready");
    check_log("mis", h0, 32'h100, 32'h200);
    check("mis_a_out", a_out, pack4(32'h100));
    check("mis_b_out", b_out, pack4(32'h200));
    ack("mis_ack", pack4(32'h100));
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
